axis_math_arbiter: RTL and testbench
====================================

AXIS_MATH_ARBITER -- requirements
Module: axis_math_arbiter

Interface
REQ-001 SHALL have parameter C_S00_AXIS_TDATA_WIDTH, default 32, input data width shared by both slave ports.
REQ-002 SHALL have parameter C_M00_AXIS_TDATA_WIDTH, default 32, output data width; must equal C_S00_AXIS_TDATA_WIDTH.
REQ-003 SHALL have parameter MAX_BEATS, default 256, maximum beats per packet before forced termination.
REQ-004 s00_axis_aclk  in  1  sole clock; one clock; all logic on its rising edge.
REQ-005 s00_axis_areset  in  1  reset, synchronous, active-high.
REQ-006 s00_axis_tdata  in  C_S00_AXIS_TDATA_WIDTH  requester 0 data.
REQ-007 s00_axis_tstrb  in  C_S00_AXIS_TDATA_WIDTH/8  requester 0 byte strobes.
REQ-008 s00_axis_tvalid / s00_axis_tlast  in  1 each  requester 0 valid, end-of-packet.
REQ-009 s00_axis_tready  out  1  requester 0 ready.
REQ-010 s01_axis_tdata / s01_axis_tstrb  in  same widths  requester 1 data, strobes.
REQ-011 s01_axis_tvalid / s01_axis_tlast  in  1 each  requester 1 valid, end-of-packet.
REQ-012 s01_axis_tready  out  1  requester 1 ready.
REQ-013 m00_axis_tdata / m00_axis_tstrb  out  C_M00_AXIS_TDATA_WIDTH, /8  to math datapath.
REQ-014 m00_axis_tvalid / m00_axis_tlast  out  1 each  output valid, end-of-packet.
REQ-015 m00_axis_tready  in  1  datapath ready.
REQ-016 trunc_flag  out  1  sticky: a packet was force-terminated.

Function
REQ-017 SHALL share one math datapath between two AXI-Stream requesters at packet granularity.
REQ-018 FSM states IDLE, GRANT0, GRANT1; IDLE after reset.
REQ-019 IDLE: only s00 valid -> GRANT0; only s01 valid -> GRANT1; both -> port not granted last (last_grant reset = 1, so s00 wins first); neither -> stay.
REQ-020 In IDLE both sX_axis_tready SHALL be 0; arbitration costs exactly one bubble cycle per packet.
REQ-021 In GRANTn only sn_axis_tready may be 1; the other port's tready SHALL be 0.
REQ-022 sn_axis_tready = grant_n AND (NOT m00_axis_tvalid OR m00_axis_tready).
REQ-023 Accepted beat (tvalid AND tready) SHALL load tdata/tstrb/tlast into output register; m00_axis_tvalid asserts next cycle; latency 1 cycle.
REQ-024 m00_axis_tvalid SHALL hold with stable tdata/tstrb/tlast until m00_axis_tready; never depends combinationally on m00_axis_tready.
REQ-025 Output register drained with no new beat accepted -> m00_axis_tvalid = 0 next cycle.
REQ-026 Beat counter resets to 0 on grant; increments per accepted beat.
REQ-027 Accepted beat with tlast = 1 -> state IDLE next cycle, last_grant = n, counter cleared.
REQ-028 Accepted beat number MAX_BEATS without tlast -> output tlast forced to 1, trunc_flag set, state IDLE; remaining input beats are arbitrated as a new packet.
REQ-029 Beat with tlast = 1 that is also beat MAX_BEATS -> normal end, trunc_flag unchanged.
REQ-030 Counter width SHALL be $clog2(MAX_BEATS+1); no wrap within a packet.
REQ-031 Deasserting tvalid mid-packet SHALL keep the grant (no preemption).

Reset
REQ-032 Reset SHALL force: state IDLE, last_grant = 1, counter 0, m00_axis_tvalid/tlast/tdata/tstrb = 0, trunc_flag = 0, both sX_axis_tready = 0 same cycle.
REQ-033 Reset mid-packet SHALL discard the held output beat; no partial packet resumes.

Structure
REQ-034 Package math_doer_pkg SHALL hold the FSM state enum (IDLE, GRANT0, GRANT1) and the default MAX_BEATS constant.
REQ-035 Single module; output register inline, no sub-module.

Verification
REQ-036 Only s00 sends 3-beat packet 0x1,0x2,0x3, m00_axis_tready = 1 -> m00 emits 0x1,0x2,0x3, tlast on 0x3, first valid 2 cycles after s00 valid.
REQ-037 Both send 2-beat packets continuously -> output order s00,s01,s00,s01; one idle cycle between packets.
REQ-038 m00_axis_tready low 5 cycles mid-packet -> tdata held stable, s00_axis_tready = 0 throughout, no beat lost or duplicated.
REQ-039 MAX_BEATS = 4, s01 sends 6-beat packet -> output beat 4 has tlast = 1, trunc_flag = 1, beats 5-6 emitted as new 2-beat packet.
REQ-040 Reset asserted on beat 2 of 4 -> m00_axis_tvalid = 0 next cycle, FSM IDLE, trunc_flag = 0.

Source files
------------

// File: rtl/math_doer_pkg.sv
// Shared types and defaults for the two-requester AXI-Stream math arbiter.
package math_doer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_e;

  localparam int DEFAULT_MAX_BEATS = 256;

endpackage

// File: rtl/axis_math_arbiter.sv
// Packet-granular arbiter sharing one AXI-Stream math datapath between two
// requesters, with a single registered output stage and forced packet cut-off.
module axis_math_arbiter
  import math_doer_pkg::*;
#(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int MAX_BEATS              = DEFAULT_MAX_BEATS
) (
  input  logic                                  s00_axis_aclk,
  input  logic                                  s00_axis_areset,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
  input  logic                                  s00_axis_tvalid,
  input  logic                                  s00_axis_tlast,
  output logic                                  s00_axis_tready,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s01_axis_tdata,
  input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   s01_axis_tstrb,
  input  logic                                  s01_axis_tvalid,
  input  logic                                  s01_axis_tlast,
  output logic                                  s01_axis_tready,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
  output logic                                  m00_axis_tvalid,
  output logic                                  m00_axis_tlast,
  input  logic                                  m00_axis_tready,
  output logic                                  trunc_flag
);

  localparam int DW = C_M00_AXIS_TDATA_WIDTH;
  localparam int SW = C_M00_AXIS_TDATA_WIDTH / 8;
  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(MAX_BEATS - 1);

  arb_state_e    state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          m_valid_q, m_valid_d;
  logic          m_last_q, m_last_d;
  logic [DW-1:0] m_data_q, m_data_d;
  logic [SW-1:0] m_strb_q, m_strb_d;
  logic          trunc_q, trunc_d;

  logic          out_free, rdy0, rdy1, sel1, accept, at_limit;
  logic          in_last;
  logic [DW-1:0] in_data;
  logic [SW-1:0] in_strb;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    m_valid_d    = m_valid_q;
    m_last_d     = m_last_q;
    m_data_d     = m_data_q;
    m_strb_d     = m_strb_q;
    trunc_d      = trunc_q;

    // Ready is gated by reset so both slaves see tready low in the reset cycle.
    out_free = !m_valid_q || m00_axis_tready;
    rdy0     = (state_q == GRANT0) && out_free && !s00_axis_areset;
    rdy1     = (state_q == GRANT1) && out_free && !s00_axis_areset;
    s00_axis_tready = rdy0;
    s01_axis_tready = rdy1;

    sel1     = (state_q == GRANT1);
    in_data  = sel1 ? s01_axis_tdata : s00_axis_tdata;
    in_strb  = sel1 ? s01_axis_tstrb : s00_axis_tstrb;
    in_last  = sel1 ? s01_axis_tlast : s00_axis_tlast;
    accept   = (s00_axis_tvalid && rdy0) || (s01_axis_tvalid && rdy1);
    at_limit = (cnt_q == LAST_IDX);

    if (m_valid_q && m00_axis_tready) m_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (s00_axis_tvalid && (!s01_axis_tvalid || last_grant_q)) begin
          state_d = GRANT0;
          cnt_d   = '0;
        end else if (s01_axis_tvalid) begin
          state_d = GRANT1;
          cnt_d   = '0;
        end
      end
      default: begin
        if (accept) begin
          m_valid_d = 1'b1;
          m_data_d  = in_data;
          m_strb_d  = in_strb;
          m_last_d  = in_last || at_limit;
          cnt_d     = cnt_q + 1'b1;
          if (in_last || at_limit) begin
            state_d      = IDLE;
            last_grant_d = sel1;
            cnt_d        = '0;
            if (!in_last) trunc_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      m_data_q     <= '0;
      m_strb_q     <= '0;
      trunc_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      m_valid_q    <= m_valid_d;
      m_last_q     <= m_last_d;
      m_data_q     <= m_data_d;
      m_strb_q     <= m_strb_d;
      trunc_q      <= trunc_d;
    end
  end

  assign m00_axis_tdata  = m_data_q;
  assign m00_axis_tstrb  = m_strb_q;
  assign m00_axis_tvalid = m_valid_q;
  assign m00_axis_tlast  = m_last_q;
  assign trunc_flag      = trunc_q;

endmodule

// File: tb/tb_axis_math_arbiter.sv
// Randomized and directed bench for axis_math_arbiter against a packet-level model.
`timescale 1ns/1ps
module tb_axis_math_arbiter;
  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s00_axis_tdata, s01_axis_tdata, m00_axis_tdata;
  logic [3:0]  s00_axis_tstrb, s01_axis_tstrb, m00_axis_tstrb;
  logic        s00_axis_tvalid, s00_axis_tlast, s00_axis_tready;
  logic        s01_axis_tvalid, s01_axis_tlast, s01_axis_tready;
  logic        m00_axis_tvalid, m00_axis_tlast, m00_axis_tready;
  logic        trunc_flag;

  always #5 clk = ~clk;

  axis_math_arbiter #(
    .C_S00_AXIS_TDATA_WIDTH(32),
    .C_M00_AXIS_TDATA_WIDTH(32),
    .MAX_BEATS(MAXB)
  ) dut (
    .s00_axis_aclk(clk), .s00_axis_areset(rst),
    .s00_axis_tdata(s00_axis_tdata), .s00_axis_tstrb(s00_axis_tstrb),
    .s00_axis_tvalid(s00_axis_tvalid), .s00_axis_tlast(s00_axis_tlast),
    .s00_axis_tready(s00_axis_tready),
    .s01_axis_tdata(s01_axis_tdata), .s01_axis_tstrb(s01_axis_tstrb),
    .s01_axis_tvalid(s01_axis_tvalid), .s01_axis_tlast(s01_axis_tlast),
    .s01_axis_tready(s01_axis_tready),
    .m00_axis_tdata(m00_axis_tdata), .m00_axis_tstrb(m00_axis_tstrb),
    .m00_axis_tvalid(m00_axis_tvalid), .m00_axis_tlast(m00_axis_tlast),
    .m00_axis_tready(m00_axis_tready),
    .trunc_flag(trunc_flag)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Source beats packed as {last, strb, data}.
  logic [36:0] q0[$], q1[$];
  int vprob = 100, rprob = 100;

  logic [31:0] lg_data[$];
  bit          lg_last[$];
  int          lg_cyc[$];

  int mdl_owner = -1;
  bit mdl_ov = 0;

  logic [31:0] exp_order[8] = '{32'hA0, 32'hA1, 32'hB0, 32'hB1, 32'hA2, 32'hA3, 32'hB2, 32'hB3};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  task automatic push_pkt(input int port, input logic [31:0] base, input int len, input bit rnd);
    for (int i = 0; i < len; i++) begin
      logic [36:0] b;
      b = {(i == len - 1), rnd ? 4'($urandom) : 4'hF, rnd ? $urandom : base + 32'(i)};
      if (port == 0) q0.push_back(b); else q1.push_back(b);
    end
  endtask

  task automatic clear_log();
    lg_data.delete(); lg_last.delete(); lg_cyc.delete();
  endtask

  task automatic wait_log(input int n, input int budget, input string name);
    int k = 0;
    do begin @(posedge clk); k++; end while (lg_data.size() < n && k < budget);
    if (lg_data.size() < n) timeout_fail(name);
  endtask

  task automatic wait_drain(input int budget, input string name);
    int k = 0;
    do begin @(posedge clk); k++; end
    while (!(q0.size() == 0 && q1.size() == 0 && !mdl_ov && mdl_owner < 0) && k < budget);
    if (k >= budget) timeout_fail(name);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; q0.delete(); q1.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Source and sink driver: AXI-Stream compliant valid hold, random throttling.
  initial begin
    bit hs0, hs1;
    s00_axis_tvalid = 0; s00_axis_tdata = '0; s00_axis_tstrb = '0; s00_axis_tlast = 0;
    s01_axis_tvalid = 0; s01_axis_tdata = '0; s01_axis_tstrb = '0; s01_axis_tlast = 0;
    m00_axis_tready = 0;
    forever begin
      @(negedge clk);
      hs0 = s00_axis_tvalid && s00_axis_tready;
      hs1 = s01_axis_tvalid && s01_axis_tready;
      @(posedge clk); #1;
      if (hs0 && q0.size() > 0) void'(q0.pop_front());
      if (hs1 && q1.size() > 0) void'(q1.pop_front());
      if (q0.size() == 0) s00_axis_tvalid = 0;
      else if (!(s00_axis_tvalid && !hs0)) s00_axis_tvalid = ($urandom_range(0, 99) < vprob);
      if (q1.size() == 0) s01_axis_tvalid = 0;
      else if (!(s01_axis_tvalid && !hs1)) s01_axis_tvalid = ($urandom_range(0, 99) < vprob);
      {s00_axis_tlast, s00_axis_tstrb, s00_axis_tdata} = (q0.size() > 0) ? q0[0] : 37'd0;
      {s01_axis_tlast, s01_axis_tstrb, s01_axis_tdata} = (q1.size() > 0) ? q1[0] : 37'd0;
      m00_axis_tready = ($urandom_range(0, 99) < rprob);
    end
  end

  // Reference model: who owns the datapath, how many beats it has sent, and
  // the one beat sitting in the output slot; compared every cycle.
  initial begin
    int          last_owner, nb;
    bit          ol, tr, er0, er1, acc, bl;
    logic [31:0] od, bd;
    logic [3:0]  os, bs;
    last_owner = 1; nb = 0; ol = 0; tr = 0; od = '0; os = '0;
    forever begin
      @(negedge clk);
      er0 = !rst && mdl_owner == 0 && (!mdl_ov || m00_axis_tready);
      er1 = !rst && mdl_owner == 1 && (!mdl_ov || m00_axis_tready);
      chk("s00_tready", s00_axis_tready, er0);
      chk("s01_tready", s01_axis_tready, er1);
      chk("m_tvalid", m00_axis_tvalid, mdl_ov);
      chk("trunc_flag", trunc_flag, tr);
      if (mdl_ov) begin
        chk("m_tdata", m00_axis_tdata, od);
        chk("m_tstrb", m00_axis_tstrb, os);
        chk("m_tlast", m00_axis_tlast, ol);
      end
      if (m00_axis_tvalid && m00_axis_tready) begin
        lg_data.push_back(m00_axis_tdata); lg_last.push_back(m00_axis_tlast); lg_cyc.push_back(cyc);
      end
      if (rst) begin
        mdl_owner = -1; last_owner = 1; nb = 0; mdl_ov = 0; ol = 0; tr = 0; od = '0; os = '0;
      end else begin
        acc = (mdl_owner == 0 && s00_axis_tvalid && er0) || (mdl_owner == 1 && s01_axis_tvalid && er1);
        if (mdl_ov && m00_axis_tready) mdl_ov = 0;
        if (acc) begin
          if (mdl_owner == 0) {bl, bs, bd} = {s00_axis_tlast, s00_axis_tstrb, s00_axis_tdata};
          else                {bl, bs, bd} = {s01_axis_tlast, s01_axis_tstrb, s01_axis_tdata};
          nb++;
          mdl_ov = 1; od = bd; os = bs; ol = bl || (nb == MAXB);
          if (ol) begin
            if (!bl) tr = 1;
            last_owner = mdl_owner; mdl_owner = -1; nb = 0;
          end
        end else if (mdl_owner < 0) begin
          if (s00_axis_tvalid && s01_axis_tvalid) mdl_owner = 1 - last_owner;
          else if (s00_axis_tvalid) mdl_owner = 0;
          else if (s01_axis_tvalid) mdl_owner = 1;
        end
      end
    end
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin
    int c0, k, total;
    logic [31:0] hold;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_tvalid", m00_axis_tvalid, 0);
    chk("reset_tdata", m00_axis_tdata, 0);
    chk("reset_tstrb", m00_axis_tstrb, 0);
    chk("reset_tlast", m00_axis_tlast, 0);
    chk("reset_trunc", trunc_flag, 0);
    chk("reset_readys", {s00_axis_tready, s01_axis_tready}, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Single 3-beat packet from s00, two-cycle latency.
    clear_log();
    push_pkt(0, 32'h1, 3, 0);
    k = 0;
    do begin @(negedge clk); k++; end while (!s00_axis_tvalid && k < 20);
    c0 = cyc;
    wait_log(3, 50, "three_beat_wait");
    chk("three_beat_d0", lg_data[0], 1);
    chk("three_beat_d1", lg_data[1], 2);
    chk("three_beat_d2", lg_data[2], 3);
    chk("three_beat_last", {lg_last[0], lg_last[1], lg_last[2]}, 3'b001);
    chk("three_beat_latency", lg_cyc[0] - c0, 2);
    wait_drain(100, "drain1");

    // Both requesters back to back: alternation with one bubble per packet.
    do_reset();
    clear_log();
    push_pkt(0, 32'hA0, 2, 0); push_pkt(0, 32'hA2, 2, 0);
    push_pkt(1, 32'hB0, 2, 0); push_pkt(1, 32'hB2, 2, 0);
    wait_log(8, 100, "alternate_wait");
    for (int i = 0; i < 8; i++) begin
      chk("alternate_data", lg_data[i], exp_order[i]);
      chk("alternate_last", lg_last[i], 64'(i % 2));
    end
    for (int i = 1; i < 8; i++) chk("alternate_spacing", lg_cyc[i] - lg_cyc[i-1], 64'((i % 2 == 0) ? 2 : 1));
    wait_drain(100, "drain2");

    // Sink stall mid-packet.
    clear_log();
    push_pkt(0, 32'hC0, 4, 0);
    wait_log(1, 50, "stall_wait");
    rprob = 0;
    @(negedge clk);
    hold = m00_axis_tdata;
    chk("stall_valid", m00_axis_tvalid, 1);
    repeat (5) begin
      chk("stall_s00_ready", s00_axis_tready, 0);
      chk("stall_data_stable", m00_axis_tdata, hold);
      @(negedge clk);
    end
    @(posedge clk);
    rprob = 100;
    wait_log(4, 50, "stall_resume_wait");
    for (int i = 0; i < 4; i++) chk("stall_order", lg_data[i], 32'hC0 + 32'(i));
    wait_drain(100, "drain3");

    // Packet ending exactly on MAX_BEATS is a normal end.
    do_reset();
    clear_log();
    push_pkt(1, 32'hF0, 4, 0);
    wait_log(4, 50, "exact_wait");
    chk("exact_last", {lg_last[0], lg_last[1], lg_last[2], lg_last[3]}, 4'b0001);
    wait_drain(100, "drain4");
    chk("exact_no_trunc", trunc_flag, 0);

    // 6-beat packet truncated at 4, tail sent as its own packet.
    clear_log();
    push_pkt(1, 32'hD0, 6, 0);
    wait_log(6, 60, "trunc_wait");
    chk("trunc_last", {lg_last[0], lg_last[1], lg_last[2], lg_last[3], lg_last[4], lg_last[5]}, 6'b000101);
    for (int i = 0; i < 6; i++) chk("trunc_data", lg_data[i], 32'hD0 + 32'(i));
    wait_drain(100, "drain5");
    chk("trunc_sticky", trunc_flag, 1);

    // Reset on beat 2 of 4 discards the packet.
    clear_log();
    push_pkt(0, 32'hE0, 4, 0);
    wait_log(1, 50, "reset_mid_wait");
    #1 rst = 1'b1;
    q0.delete(); q1.delete();
    @(negedge clk);
    @(negedge clk);
    chk("reset_mid_valid", m00_axis_tvalid, 0);
    chk("reset_mid_trunc", trunc_flag, 0);
    chk("reset_mid_readys", {s00_axis_tready, s01_axis_tready}, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    chk("reset_mid_no_resume", lg_data.size(), 2);

    // Randomized traffic with throttling on both sides.
    do_reset();
    clear_log();
    total = 0;
    for (int ep = 0; ep < 4; ep++) begin
      vprob = 40 + 20 * ep;
      rprob = 90 - 20 * ep;
      for (int p = 0; p < 12; p++) begin
        int l0, l1;
        l0 = $urandom_range(1, 7); l1 = $urandom_range(1, 7);
        push_pkt(0, 0, l0, 1); push_pkt(1, 0, l1, 1);
        total += l0 + l1;
      end
      wait_drain(6000, "random_drain");
    end
    chk("random_beat_count", lg_data.size(), total);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
